// File: rtl/ccr_branch_unit_pkg.sv
// Shared definitions for the condition-code register / branch unit:
// CCR layout, jump-type encodings and the jump decode helpers.
package ccr_branch_unit_pkg;

    localparam int CCR_W = 3;
    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    typedef enum logic [1:0] {
        JT_JZ  = 2'b00,
        JT_JN  = 2'b01,
        JT_JC  = 2'b10,
        JT_JMP = 2'b11
    } jump_type_e;

    // Condition for a jump against a given flag set; JMP is always true.
    function automatic logic jump_cond(input logic [CCR_W-1:0] flags, input jump_type_e jt);
        logic cond;
        case (jt)
            JT_JZ:   cond = flags[CCR_Z];
            JT_JN:   cond = flags[CCR_N];
            JT_JC:   cond = flags[CCR_C];
            JT_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

    // One-hot of the flag a taken conditional jump consumes; JMP consumes none.
    function automatic logic [CCR_W-1:0] jump_clear_mask(input jump_type_e jt);
        logic [CCR_W-1:0] m;
        case (jt)
            JT_JZ:   m = 3'b001;
            JT_JN:   m = 3'b010;
            JT_JC:   m = 3'b100;
            JT_JMP:  m = 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ccr_branch_unit_if.sv
// Execute-side bus of the CCR/branch unit: flag updates, jump requests,
// interrupt save/restore controls and the resulting status.
interface ccr_branch_unit_if;
    import ccr_branch_unit_pkg::*;

    logic [CCR_W-1:0] alu_ccr;
    logic [CCR_W-1:0] ccr_mask;
    logic             jmp_valid;
    logic [1:0]       jmp_type;
    logic             int_save;
    logic             rti_restore;
    logic             stall;
    logic [CCR_W-1:0] ccr_out;
    logic             branch_taken;
    logic             stack_empty;
    logic             stack_full;
    logic             stack_err;

    modport master (
        output alu_ccr, ccr_mask, jmp_valid, jmp_type, int_save, rti_restore, stall,
        input  ccr_out, branch_taken, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  alu_ccr, ccr_mask, jmp_valid, jmp_type, int_save, rti_restore, stall,
        output ccr_out, branch_taken, stack_empty, stack_full, stack_err
    );

endinterface

// File: rtl/ccr_branch_unit_stack.sv
// Saturating LIFO of CCR frames for nested interrupts; owns the frame
// pointer and the sticky overflow/underflow/conflict error flag.
module ccr_branch_unit_stack
    import ccr_branch_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             push,
    input  logic             pop,
    input  logic [CCR_W-1:0] push_data,
    output logic [CCR_W-1:0] pop_data,
    output logic             pop_ok,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PW-1:0]    ptr_q, ptr_d, ptr_m1_s;
    logic             err_q, err_d;
    logic [CCR_W-1:0] mem_q [STACK_DEPTH];
    logic [CCR_W-1:0] mem_d [STACK_DEPTH];
    logic [IW-1:0]    wr_idx_s, rd_idx_s;
    logic             push_ok_s, err_set_s;

    assign empty     = (ptr_q == {PW{1'b0}});
    assign full      = (ptr_q == PW'(STACK_DEPTH));
    assign ptr_m1_s  = ptr_q - PW'(1);
    assign wr_idx_s  = ptr_q[IW-1:0];
    assign rd_idx_s  = ptr_m1_s[IW-1:0];
    assign pop_data  = mem_q[rd_idx_s];
    assign err       = err_q;

    // A simultaneous push and pop is a conflict: neither side acts.
    assign push_ok_s = push & ~pop & ~full;
    assign pop_ok    = pop & ~push & ~empty;
    assign err_set_s = (push & pop) | (push & full) | (pop & empty);

    // Next pointer, frame contents and error flag; stall freezes everything.
    always_comb begin
        ptr_d = ptr_q;
        err_d = err_q;
        mem_d = mem_q;
        if (stall) begin
            ptr_d = ptr_q;
            err_d = err_q;
        end else begin
            if (push_ok_s) begin
                mem_d[wr_idx_s] = push_data;
                ptr_d           = ptr_q + PW'(1);
            end else if (pop_ok) begin
                ptr_d = ptr_m1_s;
            end else begin
                ptr_d = ptr_q;
            end
            if (err_set_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Stack state registers; reset discards every frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {PW{1'b0}};
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= {CCR_W{1'b0}};
            end
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/ccr_branch_unit.sv
// Architectural CCR {C,N,Z} with masked updates, conditional-jump resolution
// and interrupt flag save/restore. Define CCR_FWD_EN to resolve jumps against
// the same-cycle merged ALU flags instead of the registered CCR.
module ccr_branch_unit
    import ccr_branch_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ccr_branch_unit_if.slave  bus
);

    logic [CCR_W-1:0] ccr_q, ccr_d;
    logic [CCR_W-1:0] merged_s, eval_s, pop_data_s;
    jump_type_e       jt_s;
    logic             taken_s, pop_ok_s;
    logic             empty_s, full_s, err_s;

    assign jt_s     = jump_type_e'(bus.jmp_type);
    assign merged_s = (bus.alu_ccr & bus.ccr_mask) | (ccr_q & ~bus.ccr_mask);

`ifdef CCR_FWD_EN
    assign eval_s = merged_s;
`else
    assign eval_s = ccr_q;
`endif

    // Decision is deliberately not gated by stall so fetch sees it every cycle.
    assign taken_s = bus.jmp_valid & jump_cond(eval_s, jt_s);

    // Restore beats everything; otherwise masked merge, then the jump clear.
    always_comb begin
        ccr_d = ccr_q;
        if (bus.stall) begin
            ccr_d = ccr_q;
        end else if (pop_ok_s) begin
            ccr_d = pop_data_s;
        end else if (taken_s) begin
            ccr_d = merged_s & ~jump_clear_mask(jt_s);
        end else begin
            ccr_d = merged_s;
        end
    end

    // Architectural CCR register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_q <= {CCR_W{1'b0}};
        end else begin
            ccr_q <= ccr_d;
        end
    end

    ccr_branch_unit_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .stall     (bus.stall),
        .push      (bus.int_save),
        .pop       (bus.rti_restore),
        .push_data (ccr_q),
        .pop_data  (pop_data_s),
        .pop_ok    (pop_ok_s),
        .empty     (empty_s),
        .full      (full_s),
        .err       (err_s)
    );

    assign bus.ccr_out      = ccr_q;
    assign bus.branch_taken = taken_s;
    assign bus.stack_empty  = empty_s;
    assign bus.stack_full   = full_s;
    assign bus.stack_err    = err_s;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed plus randomized bench for ccr_branch_unit against a queue-based
// reference model of the flag register, jump rules and interrupt frame stack.
module tb_ccr_branch_unit;

    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [2:0] m_ccr;
    logic [2:0] m_stack[$];
    logic       m_err;

    ccr_branch_unit_if bus ();

    ccr_branch_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ccr_out"},     8'(bus.ccr_out),     8'(m_ccr));
        check({tag, ".stack_empty"}, 8'(bus.stack_empty), 8'(m_stack.size() == 0));
        check({tag, ".stack_full"},  8'(bus.stack_full),  8'(m_stack.size() == DEPTH));
        check({tag, ".stack_err"},   8'(bus.stack_err),   8'(m_err));
    endtask

    // One clock of stimulus: check the combinational decision, then the registered result.
    task automatic cyc(input string tag, input logic [2:0] alu, input logic [2:0] mask,
                       input logic jv, input logic [1:0] jt,
                       input logic is, input logic rti, input logic st);
        logic [2:0] merged, f, nc;
        logic       exp_taken;
        bit         popped;
        bus.alu_ccr = alu; bus.ccr_mask = mask; bus.jmp_valid = jv; bus.jmp_type = jt;
        bus.int_save = is; bus.rti_restore = rti; bus.stall = st;
        #1;
        merged = (alu & mask) | (m_ccr & ~mask);
`ifdef CCR_FWD_EN
        f = merged;
`else
        f = m_ccr;
`endif
        exp_taken = jv && ((jt == 2'd3) || (((f >> jt) & 3'd1) != 3'd0));
        check({tag, ".branch_taken"}, 8'(bus.branch_taken), 8'(exp_taken));
        @(posedge clk);
        if (!st) begin
            popped = 0;
            nc = merged;
            if (is && rti) m_err = 1'b1;
            else if (is) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_ccr);
            end else if (rti) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else begin
                    nc = m_stack.pop_back();
                    popped = 1;
                end
            end
            if (!popped && exp_taken && jt != 2'd3) nc = nc & ~(3'd1 << jt);
            m_ccr = nc;
        end
        #1;
        check_state(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        bus.int_save = 1'b0; bus.rti_restore = 1'b0; bus.jmp_valid = 1'b0; bus.stall = 1'b0;
        #1;
        m_ccr = 3'b000;
        m_stack.delete();
        m_err = 1'b0;
        check_state(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ccr = 3'b000;
        m_err = 1'b0;
        rst = 1'b1;
        bus.alu_ccr = 3'b000; bus.ccr_mask = 3'b000; bus.jmp_valid = 1'b0; bus.jmp_type = 2'b00;
        bus.int_save = 1'b0; bus.rti_restore = 1'b0; bus.stall = 1'b0;
        #7;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Flag load and jump-clear rules
        cyc("load_z",   3'b001, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("load_z.value", 8'(bus.ccr_out), 8'h01);
        cyc("jz_take",  3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("jz_take.value", 8'(bus.ccr_out), 8'h00);
        cyc("load_c",   3'b100, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc("jn_not",   3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        check("jn_not.value", 8'(bus.ccr_out), 8'h04);
        cyc("jc_take",  3'b000, 3'b000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        check("jc_take.value", 8'(bus.ccr_out), 8'h00);
        cyc("load_z2",  3'b001, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc("clr_wins", 3'b001, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("clr_wins.value", 8'(bus.ccr_out), 8'h00);
        cyc("jmp",      3'b111, 3'b111, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        check("jmp.value", 8'(bus.ccr_out), 8'h07);

        // Stack round trip with overflow
        cyc("set101",   3'b101, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc("push1",    3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc("set010",   3'b010, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc("push2",    3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("push2.full", 8'(bus.stack_full), 8'h01);
        cyc("push_ovf", 3'b111, 3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("push_ovf.err", 8'(bus.stack_err), 8'h01);
        cyc("pop1",     3'b000, 3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        check("pop1.value", 8'(bus.ccr_out), 8'h02);
        cyc("pop2",     3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("pop2.value", 8'(bus.ccr_out), 8'h05);

        // Underflow and push+pop conflict
        async_reset("rst1");
        cyc("underflow", 3'b110, 3'b110, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("underflow.value", 8'(bus.ccr_out), 8'h06);
        async_reset("rst2");
        cyc("pushA",    3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc("both",     3'b011, 3'b011, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);

        // Stall freezes state, forwarding hazard, reset mid-stack
        cyc("stall",    3'b111, 3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        cyc("stall_j",  3'b000, 3'b111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        async_reset("rst3");
        cyc("fwd",      3'b001, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc("pushB",    3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc("pushC",    3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        async_reset("rst_mid");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) async_reset("rst_rand");
            cyc("rand", 3'($urandom), 3'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
